// File: rtl/axis_extremum_tracker.sv
// Multi-channel AXI-Stream sink: tracks signed min/max per channel over 2^log_count beats and
// derives a centre plus lower/upper thresholds scaled about it by 2^-shift.
module axis_extremum_tracker #(
   parameter int SAMPLE_WIDTH  = 16,
   parameter int CHANNEL_COUNT = 2,
   localparam int AXIS_TDATA_WIDTH = SAMPLE_WIDTH * CHANNEL_COUNT
) (
   input  logic                        aclk,
   input  logic                        areset,
   input  logic                        enable,
   input  logic [4:0]                  log_count,
   input  logic [2:0]                  shift,
   input  logic                        S_AXIS_tvalid,
   input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
   output logic                        S_AXIS_tready,
   output logic [AXIS_TDATA_WIDTH-1:0] lower_threshold,
   output logic [AXIS_TDATA_WIDTH-1:0] upper_threshold,
   output logic [AXIS_TDATA_WIDTH-1:0] center,
   output logic                        update
);

   localparam int W = SAMPLE_WIDTH;
   localparam int C = CHANNEL_COUNT;
   localparam logic signed [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
   localparam logic signed [W-1:0] MAX_NEG = {1'b1, {(W-1){1'b0}}};

   localparam logic STATE_IDLE    = 1'b0;
   localparam logic STATE_MEASURE = 1'b1;

   logic               state;
   logic [31:0]        counter;
   logic [31:0]        window_last;
   logic [31:0]        window_last_next;
   logic               beat_accept;

   logic signed [W-1:0] sample   [C];
   logic signed [W-1:0] run_min  [C];
   logic signed [W-1:0] run_max  [C];
   logic signed [W-1:0] beat_min [C];
   logic signed [W-1:0] beat_max [C];
   logic signed [W-1:0] snap_min [C];
   logic signed [W-1:0] snap_max [C];
   logic [2:0]          snap_shift;
   logic                snap_valid;

   logic signed [W:0]   sum_ext   [C];
   logic signed [W:0]   s1_center [C];
   logic signed [W:0]   s1_min    [C];
   logic signed [W:0]   s1_max    [C];
   logic [2:0]          s1_shift;
   logic                s1_valid;
   logic signed [W:0]   diff_lo   [C];
   logic signed [W:0]   diff_hi   [C];
   logic signed [W:0]   new_lo    [C];
   logic signed [W:0]   new_hi    [C];
   logic                unused_msbs;

   assign S_AXIS_tready    = 1'b1;
   assign beat_accept      = S_AXIS_tvalid & enable & (state == STATE_MEASURE);
   assign window_last_next = (32'd1 << log_count) - 32'd1;

   always_comb begin
      for (int c = 0; c < C; c++) begin
         sample[c]   = S_AXIS_tdata[c*W +: W];
         beat_min[c] = (sample[c] < run_min[c]) ? sample[c] : run_min[c];
         beat_max[c] = (sample[c] > run_max[c]) ? sample[c] : run_max[c];
      end
   end

   // All threshold arithmetic runs one bit wider so extreme min/max pairs cannot wrap.
   always_comb begin
      unused_msbs = 1'b0;
      for (int c = 0; c < C; c++) begin
         sum_ext[c]  = {snap_max[c][W-1], snap_max[c]} + {snap_min[c][W-1], snap_min[c]};
         diff_lo[c]  = s1_min[c] - s1_center[c];
         diff_hi[c]  = s1_max[c] - s1_center[c];
         new_lo[c]   = s1_center[c] + (diff_lo[c] >>> s1_shift);
         new_hi[c]   = s1_center[c] + (diff_hi[c] >>> s1_shift);
         unused_msbs = unused_msbs ^ new_lo[c][W] ^ new_hi[c][W] ^ s1_center[c][W];
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state       <= STATE_IDLE;
         counter     <= '0;
         window_last <= '0;
         snap_valid  <= 1'b0;
         snap_shift  <= '0;
         for (int c = 0; c < C; c++) begin
            run_min[c]  <= MAX_POS;
            run_max[c]  <= MAX_NEG;
            snap_min[c] <= MAX_POS;
            snap_max[c] <= MAX_NEG;
         end
      end else begin
         snap_valid <= 1'b0;
         case (state)
            STATE_IDLE: begin
               counter     <= '0;
               window_last <= window_last_next;
               for (int c = 0; c < C; c++) begin
                  run_min[c] <= MAX_POS;
                  run_max[c] <= MAX_NEG;
               end
               if (enable) state <= STATE_MEASURE;
            end
            STATE_MEASURE: begin
               if (!enable) begin
                  state <= STATE_IDLE;
               end else if (beat_accept) begin
                  if (counter == window_last) begin
                     // Close the window and open the next one on the same edge.
                     snap_valid  <= 1'b1;
                     snap_shift  <= shift;
                     counter     <= '0;
                     window_last <= window_last_next;
                     for (int c = 0; c < C; c++) begin
                        snap_min[c] <= beat_min[c];
                        snap_max[c] <= beat_max[c];
                        run_min[c]  <= MAX_POS;
                        run_max[c]  <= MAX_NEG;
                     end
                  end else begin
                     counter <= counter + 32'd1;
                     for (int c = 0; c < C; c++) begin
                        run_min[c] <= beat_min[c];
                        run_max[c] <= beat_max[c];
                     end
                  end
               end
            end
            default: state <= STATE_IDLE;
         endcase
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         s1_valid <= 1'b0;
         s1_shift <= '0;
         update   <= 1'b0;
         center   <= '0;
         for (int c = 0; c < C; c++) begin
            s1_center[c] <= '0;
            s1_min[c]    <= '0;
            s1_max[c]    <= '0;
            lower_threshold[c*W +: W] <= MAX_POS;
            upper_threshold[c*W +: W] <= MAX_NEG;
         end
      end else begin
         s1_valid <= snap_valid;
         update   <= s1_valid;
         if (snap_valid) begin
            s1_shift <= snap_shift;
            for (int c = 0; c < C; c++) begin
               s1_center[c] <= sum_ext[c] >>> 1;
               s1_min[c]    <= {snap_min[c][W-1], snap_min[c]};
               s1_max[c]    <= {snap_max[c][W-1], snap_max[c]};
            end
         end
         if (s1_valid) begin
            for (int c = 0; c < C; c++) begin
               lower_threshold[c*W +: W] <= new_lo[c][W-1:0];
               upper_threshold[c*W +: W] <= new_hi[c][W-1:0];
               center[c*W +: W]          <= s1_center[c][W-1:0];
            end
         end
      end
   end

endmodule

// File: tb/tb_axis_extremum_tracker.sv
// Directed bench for axis_extremum_tracker: table-driven windows plus hand sequences for
// reset, tvalid gaps with back-to-back windows, and enable abort.
module tb_axis_extremum_tracker;

   logic        aclk = 1'b0;
   logic        areset;
   logic        enable;
   logic [4:0]  log_count;
   logic [2:0]  shift;
   logic        tvalid;
   logic [31:0] tdata;
   logic        tready;
   logic [31:0] lower;
   logic [31:0] upper;
   logic [31:0] center;
   logic        update;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct packed {
      logic [4:0]        lc;
      logic [2:0]        sh;
      int                n;
      logic [0:3][15:0]  d0;
      logic [0:3][15:0]  d1;
      logic [0:5][15:0]  e;   // lo0, up0, c0, lo1, up1, c1
   } vec_t;

   vec_t vecs [6];
   logic [0:5][15:0] reset_vals;

   axis_extremum_tracker #(.SAMPLE_WIDTH(16), .CHANNEL_COUNT(2)) dut (
      .aclk            (aclk),
      .areset          (areset),
      .enable          (enable),
      .log_count       (log_count),
      .shift           (shift),
      .S_AXIS_tvalid   (tvalid),
      .S_AXIS_tdata    (tdata),
      .S_AXIS_tready   (tready),
      .lower_threshold (lower),
      .upper_threshold (upper),
      .center          (center),
      .update          (update)
   );

   always #5 aclk = ~aclk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic [0:5][15:0] e);
      check({tag, " lo0"}, lower[15:0],  e[0]);
      check({tag, " up0"}, upper[15:0],  e[1]);
      check({tag, " c0"},  center[15:0], e[2]);
      check({tag, " lo1"}, lower[31:16], e[3]);
      check({tag, " up1"}, upper[31:16], e[4]);
      check({tag, " c1"},  center[31:16], e[5]);
   endtask

   task automatic drive(input logic v, input logic [15:0] d0, input logic [15:0] d1);
      @(negedge aclk);
      tvalid = v;
      tdata  = {d1, d0};
   endtask

   // Pass through IDLE so the new log_count is latched; returns with the FSM in MEASURE.
   task automatic restart(input logic [4:0] lc, input logic [2:0] sh);
      @(negedge aclk);
      enable    = 1'b0;
      tvalid    = 1'b0;
      log_count = lc;
      shift     = sh;
      @(negedge aclk);
      enable = 1'b1;
   endtask

   // Called right after the last beat was driven: update must pulse exactly two edges later.
   task automatic tail_check(input string tag, input logic [0:5][15:0] e);
      drive(1'b0, 16'h0, 16'h0);
      @(posedge aclk); #1;
      check({tag, " early upd"}, {15'b0, update}, 16'd0);
      @(posedge aclk); #1;
      check({tag, " upd"}, {15'b0, update}, 16'd1);
      check_outs(tag, e);
      @(posedge aclk); #1;
      check({tag, " upd width"}, {15'b0, update}, 16'd0);
   endtask

   initial begin
      logic [0:5]       gap_v;
      logic [0:5][15:0] gap_d;
      logic [0:5][15:0] e_w1;
      logic [0:5][15:0] e_w2;
      logic [0:5][15:0] e_en;
      logic [0:5][15:0] e_rst;

      reset_vals = {16'h7FFF, 16'h8000, 16'h0000, 16'h7FFF, 16'h8000, 16'h0000};
      vecs[0] = '{lc: 5'd2, sh: 3'd0, n: 4,
                  d0: {16'sd10, -16'sd20, 16'sd5, 16'sd30},
                  d1: {16'sd7, 16'sd7, 16'sd7, 16'sd7},
                  e:  {-16'sd20, 16'sd30, 16'sd5, 16'sd7, 16'sd7, 16'sd7}};
      vecs[1] = '{lc: 5'd2, sh: 3'd1, n: 4,
                  d0: {16'sd10, -16'sd20, 16'sd5, 16'sd30},
                  d1: {16'sd7, 16'sd7, 16'sd7, 16'sd7},
                  e:  {-16'sd8, 16'sd17, 16'sd5, 16'sd7, 16'sd7, 16'sd7}};
      vecs[2] = '{lc: 5'd1, sh: 3'd0, n: 2,
                  d0: {16'h8000, 16'h7FFF, 16'h0, 16'h0},
                  d1: {-16'sd5, -16'sd5, 16'sd0, 16'sd0},
                  e:  {16'h8000, 16'h7FFF, 16'hFFFF, -16'sd5, -16'sd5, -16'sd5}};
      vecs[3] = '{lc: 5'd1, sh: 3'd7, n: 2,
                  d0: {16'h7FFF, 16'h8000, 16'h0, 16'h0},
                  d1: {16'sd100, -16'sd100, 16'sd0, 16'sd0},
                  e:  {-16'sd257, 16'sd255, -16'sd1, -16'sd1, 16'sd0, 16'sd0}};
      vecs[4] = '{lc: 5'd0, sh: 3'd3, n: 1,
                  d0: {16'sd123, 16'sd0, 16'sd0, 16'sd0},
                  d1: {-16'sd4, 16'sd0, 16'sd0, 16'sd0},
                  e:  {16'sd123, 16'sd123, 16'sd123, -16'sd4, -16'sd4, -16'sd4}};
      vecs[5] = '{lc: 5'd2, sh: 3'd5, n: 4,
                  d0: {-16'sd300, -16'sd300, -16'sd300, -16'sd300},
                  d1: {16'sd1, 16'sd2, 16'sd3, 16'sd4},
                  e:  {-16'sd300, -16'sd300, -16'sd300, 16'sd1, 16'sd2, 16'sd2}};

      areset = 1'b1; enable = 1'b0; log_count = 5'd0; shift = 3'd0;
      tvalid = 1'b0; tdata = '0;
      #12;
      check_outs("por", reset_vals);
      check("por upd", {15'b0, update}, 16'd0);
      check("tready", {15'b0, tready}, 16'd1);
      @(negedge aclk);
      areset = 1'b0;

      for (int v = 0; v < 6; v++) begin
         restart(vecs[v].lc, vecs[v].sh);
         for (int i = 0; i < vecs[v].n; i++) drive(1'b1, vecs[v].d0[i], vecs[v].d1[i]);
         tail_check($sformatf("vec%0d", v), vecs[v].e);
      end

      // tvalid gaps, window of 2, second window starts right after the first closes.
      gap_v = 6'b101101;
      gap_d = {16'sd1, 16'sd99, 16'sd2, 16'sd3, -16'sd99, 16'sd4};
      e_w1  = {16'sd1, 16'sd2, 16'sd1, 16'sd1, 16'sd2, 16'sd1};
      e_w2  = {16'sd3, 16'sd4, 16'sd3, 16'sd3, 16'sd4, 16'sd3};
      restart(5'd1, 3'd0);
      for (int k = 0; k < 9; k++) begin
         if (k < 6) drive(gap_v[k], gap_d[k], gap_d[k]);
         else drive(1'b0, 16'h0, 16'h0);
         @(posedge aclk); #1;
         if (k == 4) begin
            check("gap upd w1", {15'b0, update}, 16'd1);
            check_outs("gap w1", e_w1);
         end else if (k == 7) begin
            check("gap upd w2", {15'b0, update}, 16'd1);
            check_outs("gap w2", e_w2);
         end else begin
            check($sformatf("gap idle%0d", k), {15'b0, update}, 16'd0);
         end
      end

      // Enable dropped mid-window: partial window discarded, outputs held.
      restart(5'd2, 3'd0);
      drive(1'b1, 16'sd1000, 16'sd1000);
      drive(1'b1, 16'sd2000, 16'sd2000);
      @(negedge aclk);
      enable = 1'b0;
      tvalid = 1'b1;
      tdata  = {16'sd5000, 16'sd5000};
      repeat (3) begin
         @(posedge aclk); #1;
         check("dis upd", {15'b0, update}, 16'd0);
         check_outs("dis hold", e_w2);
      end
      @(negedge aclk);
      enable = 1'b1;
      @(posedge aclk); #1;
      check("reen idle upd", {15'b0, update}, 16'd0);
      drive(1'b1, -16'sd50, 16'sd0);
      drive(1'b1, 16'sd60, 16'sd0);
      drive(1'b1, -16'sd70, 16'sd0);
      drive(1'b1, 16'sd80, 16'sd0);
      e_en = {-16'sd70, 16'sd80, 16'sd5, 16'sd0, 16'sd0, 16'sd0};
      tail_check("reen", e_en);

      // Reset while a result is in the pipeline: no pulse, immediate reset values.
      restart(5'd2, 3'd0);
      for (int i = 0; i < 4; i++) drive(1'b1, vecs[0].d0[i], vecs[0].d1[i]);
      drive(1'b0, 16'h0, 16'h0);
      @(posedge aclk); #3;
      areset = 1'b1;
      #1;
      check_outs("arst", reset_vals);
      check("arst upd", {15'b0, update}, 16'd0);
      @(posedge aclk); #1;
      check("arst no pulse", {15'b0, update}, 16'd0);
      check_outs("arst hold", reset_vals);
      @(negedge aclk);
      areset = 1'b0;
      restart(5'd2, 3'd0);
      drive(1'b1, 16'sd1, 16'sd0);
      drive(1'b1, 16'sd2, 16'sd0);
      drive(1'b1, 16'sd3, 16'sd0);
      for (int k = 0; k < 5; k++) begin
         drive(1'b0, 16'h0, 16'h0);
         @(posedge aclk); #1;
         check($sformatf("post rst wait%0d", k), {15'b0, update}, 16'd0);
      end
      drive(1'b1, 16'sd4, 16'sd0);
      e_rst = {16'sd1, 16'sd4, 16'sd2, 16'sd0, 16'sd0, 16'sd0};
      tail_check("post rst", e_rst);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
